// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-read-port register file.
// Feature macro REGFILE_ZERO_REG_EN is consumed by regfile_mrp, not here.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  // A single-entry file still needs one address bit.
  function automatic int calc_addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Low bit of lane `idx` in a packed bus of `width`-bit lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_rd_sel.sv
// Combinational NUM_REGS:1 select over a flattened entry bus; addresses
// beyond the last entry return zero.
module regfile_rd_sel
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = calc_addr_w(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]          sel_addr,
  input  logic [NUM_REGS*DATA_W-1:0] entries,
  output logic [DATA_W-1:0]          sel_data
);

  // NOTE: the default before the loop keeps every path assigned, so no latch
  // is inferred; it also yields the zero for out-of-range addresses.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == ADDR_W'(i)) sel_data = entries[slice_lo(i, DATA_W) +: DATA_W];
    end
  end

endmodule

// File: rtl/regfile_mrp.sv
// Register file with one write port and NUM_RD registered read ports with
// same-cycle write bypass. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mrp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  localparam int ADDR_W   = calc_addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

`ifdef REGFILE_ZERO_REG_EN
  localparam int FIRST_WR = 1;
`else
  localparam int FIRST_WR = 0;
`endif

  logic [DATA_W-1:0]          mem_q [NUM_REGS];
  logic [DATA_W-1:0]          mem_d [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] mem_flat;
  logic [NUM_RD*DATA_W-1:0]   sel_flat;
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]          rd_valid_q, rd_valid_d;
  logic                       wr_hit;

  // wr_hit is set only when the write actually lands in storage, so
  // dropped writes (out of range, or the hardwired zero entry) never bypass.
  always_comb begin
    mem_d  = mem_q;
    wr_hit = 1'b0;
    for (int i = FIRST_WR; i < NUM_REGS; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) begin
        mem_d[i] = wr_data;
        wr_hit   = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign mem_flat[slice_lo(g, DATA_W) +: DATA_W] = mem_q[g];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_sel #(
      .DATA_W  (DATA_W),
      .NUM_REGS(NUM_REGS),
      .ADDR_W  (ADDR_W)
    ) u_sel (
      .sel_addr(rd_addr[slice_lo(p, ADDR_W) +: ADDR_W]),
      .entries (mem_flat),
      .sel_data(sel_flat[slice_lo(p, DATA_W) +: DATA_W])
    );
  end

  // Idle ports hold their last data so downstream operands do not toggle.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_req;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_req[p]) begin
        if (wr_hit && wr_addr == rd_addr[slice_lo(p, ADDR_W) +: ADDR_W])
          rd_data_d[slice_lo(p, DATA_W) +: DATA_W] = wr_data;
        else
          rd_data_d[slice_lo(p, DATA_W) +: DATA_W] = sel_flat[slice_lo(p, DATA_W) +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values. The storage array is reset too: outputs must never be X
  // after reset, whatever address is read first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mrp.sv
// Bench for regfile_mrp: a 32-entry and a 24-entry instance share stimulus and
// are compared each cycle against an array model; honours REGFILE_ZERO_REG_EN.
module tb_regfile_mrp;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_req;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data32, rd_data24;
  logic [1:0]  rd_valid32, rd_valid24;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_mrp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data32), .rd_valid(rd_valid32)
  );

  regfile_mrp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2)) u_dut24 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data24), .rd_valid(rd_valid24)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Array model: storage contents plus the value each port must show next.
  logic [31:0] m32 [32];
  logic [31:0] m24 [24];
  logic [31:0] e32 [2];
  logic [31:0] e24 [2];
  logic [1:0]  ev32, ev24;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m32[i] = 32'h0;
      for (int i = 0; i < 24; i++) m24[i] = 32'h0;
      for (int p = 0; p < 2; p++) begin e32[p] = 32'h0; e24[p] = 32'h0; end
      ev32 = 2'b00;
      ev24 = 2'b00;
    end else begin
      bit w32, w24;
      w32 = wr_en && !(ZERO_EN && wr_addr == 5'd0);
      w24 = w32 && (wr_addr < 5'd24);
      ev32 = rd_req;
      ev24 = rd_req;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        if (rd_req[p]) begin
          e32[p] = (w32 && wr_addr == a) ? wr_data : m32[a];
          if (a >= 5'd24)                e24[p] = 32'h0;
          else if (w24 && wr_addr == a)  e24[p] = wr_data;
          else                           e24[p] = m24[a];
        end
      end
      if (w32) m32[wr_addr] = wr_data;
      if (w24) m24[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("cmp32_data%0d", p), rd_data32[p*32 +: 32], e32[p]);
        check($sformatf("cmp32_valid%0d", p), {31'b0, rd_valid32[p]}, {31'b0, ev32[p]});
        check($sformatf("cmp24_data%0d", p), rd_data24[p*32 +: 32], e24[p]);
        check($sformatf("cmp24_valid%0d", p), {31'b0, rd_valid24[p]}, {31'b0, ev24[p]});
      end
    end
  end

  // Apply one cycle of inputs; on return the resulting outputs are visible.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] req, input logic [4:0] a0, input logic [4:0] a1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_req  = req;
    rd_addr = {a1, a0};
    @(negedge clk);
  endtask

  function automatic logic [31:0] p32(input int p);
    return rd_data32[p*32 +: 32];
  endfunction

  function automatic logic [31:0] p24(input int p);
    return rd_data24[p*32 +: 32];
  endfunction

  logic [31:0] zexp;

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Random writes, two idle cycles, then a reset cycle carrying a write and read.
    for (int i = 0; i < 6; i++) drive(1'b1, 5'($urandom_range(0, 31)), $urandom, 2'b00, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'hBAD0_0003, 2'b01, 5'd3, 5'd0);
    rst = 1'b0;
    check("rst_valid", {30'b0, rd_valid32}, 32'h0);
    check("rst_data0", p32(0), 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(31 - i));
      if (i == 0) check("rst_rd0_valid", {30'b0, rd_valid32}, 32'h3);
      if (i == 3) check("rst_rd3_data", p32(0), 32'h0);
    end
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    check("rst_idle_valid", {30'b0, rd_valid32}, 32'h0);

    // Write/readback sweep with crossed port addresses.
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 32'hA5A5_0000 + i, 2'b00, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(31 - i));
      if (i == 10) check("sweep_p0_10", p32(0), 32'hA5A5_000A);
      if (i == 11) check("sweep_p0_11", p32(0), 32'hA5A5_000B);
      if (i == 12) check("sweep_p1_19", p32(1), 32'hA5A5_0013);
      if (i == 31) check("sweep_p1_0", p32(1), ZERO_EN ? 32'h0 : 32'hA5A5_0000);
    end

    // Same-cycle bypass on both ports.
    drive(1'b1, 5'd7, 32'h1111_1111, 2'b00, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 32'h2222_2222, 2'b11, 5'd7, 5'd7);
    check("byp_p0", p32(0), 32'h2222_2222);
    check("byp_p1", p32(1), 32'h2222_2222);
    check("byp24_p1", p24(1), 32'h2222_2222);

    // Held address, data changes underneath.
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0);
    check("hold_old", p32(0), 32'hA5A5_0005);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b01, 5'd5, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0);
    check("hold_new", p32(0), 32'hDEAD_BEEF);

    // Out-of-range addresses on the 24-entry instance.
    drive(1'b1, 5'd30, 32'h3030_3030, 2'b00, 5'd0, 5'd0);
    drive(1'b1, 5'd24, 32'h2424_2424, 2'b00, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd30, 5'd6);
    check("oor24_data", p24(0), 32'h0);
    check("oor24_valid", {31'b0, rd_valid24[0]}, 32'h1);
    check("oor24_alias6", p24(1), 32'hA5A5_0006);
    check("oor32_data", p32(0), 32'h3030_3030);
    drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd24, 5'd14);

    // Entry 0: plain register or hardwired zero depending on build.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b00, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0);
    check("zero_rd", p32(0), ZERO_EN ? 32'h0 : 32'hFFFF_FFFF);
    zexp = ZERO_EN ? 32'h0 : 32'h0F0F_0F0F;
    drive(1'b1, 5'd0, 32'h0F0F_0F0F, 2'b11, 5'd0, 5'd0);
    check("zero_byp_p0", p32(0), zexp);
    check("zero_byp_p1", p32(1), zexp);

    // Dropping requests clears valid and holds data.
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd9);
    check("idle_valid", {30'b0, rd_valid32}, 32'h0);
    check("idle_hold", p32(1), zexp);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mrp.md
Name: regfile_mrp

Overview:
- Parametrised multi-read-port register file: NUM_REGS entries of DATA_W bits, one write port, NUM_RD independent read ports.
- Reads are registered with 1-cycle latency and a valid flag; same-cycle write-to-read bypass is included.
- Sits between decode (read addresses) and execute (operands); replaces the fixed 32x32 storage plus per-port 32:1 select.

Parameters:
- DATA_W, 32, bits per register
- NUM_REGS, 32, number of registers (2..256, need not be a power of 2)
- NUM_RD, 2, number of read ports (1..4)
- ADDR_W, $clog2(NUM_REGS), address width (derived, not to be overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port p uses [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port valid, asserted the cycle after rd_req

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- On rst: every storage entry becomes 0, rd_data becomes 0, rd_valid becomes 0. Writes and reads in the rst cycle are ignored.
- Write: on a rising edge with wr_en=1 and wr_addr<NUM_REGS, mem[wr_addr] <= wr_data. If wr_addr>=NUM_REGS, the write is dropped and no entry changes.
- Read, port p: if rd_req[p]=1 in cycle N, then in cycle N+1 rd_valid[p]=1 and rd_data[p] holds the selected value.
- If rd_req[p]=0, rd_valid[p] goes to 0 the next cycle and rd_data[p] holds its previous value (no toggling).
- Select is a full combinational decode of rd_addr over all entries. Every bit of data is in the logic cone; no partial sensitivity. Slice p*DATA_W+DATA_W-1 : p*DATA_W exactly, with no overlapping or short slices.
- Bypass: if wr_en=1, wr_addr==rd_addr[p] and rd_req[p]=1 in the same cycle, rd_data[p] returns wr_data (new value), not the old entry.
- Address out of range (rd_addr>=NUM_REGS): rd_data[p]=0, rd_valid[p] still 1.
- Multiple ports reading the same address: all return the identical value, including the bypass case.
- Throughput: one read per port per cycle; back-to-back requests are fully pipelined with no stalls.
- No X on outputs after reset, for any input sequence.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero. Writes to address 0 are discarded, reads of address 0 return 0, and bypass never applies to address 0.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Package regfile_pkg holds the default DATA_W/NUM_REGS/NUM_RD constants, a function computing ADDR_W, and a packed-port slice helper (index-to-offset).
- One natural sub-module: regfile_rd_sel, a purely combinational parametrised NUM_REGS:1 DATA_W-bit select with out-of-range zeroing.
  - It is instantiated NUM_RD times.
  - Bypass muxing and output registers stay in the top.

Test Plan:
- Reset check: assert rst 2 cycles after random writes, then read all 32 addresses on both ports -> all rd_data=0, rd_valid high exactly 1 cycle after each rd_req.
- Write/readback sweep: write mem[i]=32'hA5A5_0000+i for i=0..31, then read i on port0 and 31-i on port1 each cycle -> correct values at N+1 for every slot, including slices 10, 11, 12 (boundary regression).
- Bypass: mem[7]=32'h1111_1111; same cycle wr_en, wr_addr=7, wr_data=32'h2222_2222, rd_req=2'b11, both rd_addr=7 -> both ports return 32'h2222_2222 next cycle.
- Data-only change: hold rd_addr[0]=5 with rd_req=1 while writing mem[5]=32'hDEAD_BEEF -> port0 shows the new value on the second cycle after the write (sensitivity/regression check).
- Non-power-of-2 config NUM_REGS=24, ADDR_W=5: write to 30 -> no entry changes; read 30 -> rd_data=0, rd_valid=1.
- With REGFILE_ZERO_REG_EN: write 32'hFFFF_FFFF to 0, then read 0 (including same-cycle bypass) -> 0. Without the macro -> 32'hFFFF_FFFF.
